mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// Sequences and shares the single-port synchronous 128x24 MEMORY between the
// instruction-fetch unit and the data/stack unit. Arbitrates requests, drives
// MAR/data_in/EN/CS, resolves indirect ([[M]]) loads as two back-to-back reads,
// and returns read data with a valid pulse. Sits between the CPU control path and MEMORY.
// PARAMETERS
// AW       8   address width (MAR)
// DW       24  word width
// DEPTH    128 implemented cells; an address >= DEPTH is an error
// MEM_LAT  1   cycles from the EN-sampling edge to data_out being usable (>=1)
// PORTS
// clk          in   1   single clock, all state on posedge
// reset        in   1   asynchronous, active-high; clears all state
// if_req       in   1   fetch request; held high until if_gnt
// if_addr      in   AW  fetch address
// if_gnt       out  1   1-cycle pulse: fetch request accepted
// if_rvalid    out  1   1-cycle pulse: if_rdata valid
// if_rdata     out  DW  fetched word (held until the next fetch response)
// d_req        in   1   data request; op/addr/wdata held stable until d_gnt
// d_op         in   2   00 read, 01 write, 10 indirect read, 11 reserved (= error)
// d_addr       in   AW  data address or pointer address
// d_wdata      in   DW  write data
// d_gnt        out  1   1-cycle pulse: data request accepted
// d_rvalid     out  1   1-cycle pulse: d_rdata / d_err valid
// d_rdata      out  DW  read result (0 on error)
// d_err        out  1   qualifies d_rvalid: address/pointer out of range or bad op
// mem_MAR      out  AW  to MEMORY.MAR
// mem_data_in  out  DW  to MEMORY.data_in
// mem_EN       out  1   to MEMORY.EN; high for exactly one cycle per access
// mem_CS       out  1   to MEMORY.CS; 1 write, 0 read
// mem_data_out in   DW  from MEMORY.data_out
// busy         out  1   high in every state other than IDLE
// BEHAVIOUR
// - Reset: every output 0; state IDLE; round-robin pointer = "data last", so fetch wins the first tie.
// - Reset asserted mid-operation: mem_EN drops immediately, so no write is committed at the next edge. The access is abandoned with no response.
// - FSM: IDLE -> ISSUE -> WAIT -> (RESP | IND_ISSUE -> IND_WAIT -> RESP) -> IDLE; a write goes ISSUE -> IDLE.
// - IDLE: with a request pending, grant it (gnt pulse in cycle G) and register MAR/CS/data_in.
//   Both pending: grant the requester not granted last. One pending: grant it.
// - ISSUE (G+1): mem_EN=1. A write completes at the end of this cycle with no rvalid.
// - WAIT: count MEM_LAT cycles, then capture mem_data_out. Plain read: rvalid in cycle G+2+MEM_LAT (G+3 by default).
// - Indirect: the captured word[AW-1:0] becomes the pointer and a second EN is issued in IND_ISSUE.
//   rvalid comes in G+4+2*MEM_LAT (G+6). Pointer bits above AW are ignored.
// - Error: addr >= DEPTH or op 11 -> grant, no EN, RESP with d_rvalid=1, d_err=1, d_rdata=0 at G+1.
//   This applies to writes as well. Indirect with pointer >= DEPTH -> error response in place of the second EN.
// - No request is granted while busy. Requests arriving while busy wait, and are re-arbitrated in the first IDLE cycle.
// - Each response port pulses only for its own transaction; the idle response port holds rvalid at 0.
// STRUCTURE
// - Shared package mem_ctrl_pkg: d_op encodings, FSM state encoding, AW/DW/DEPTH defaults. The CPU decode and the bench import it.
// - One sub-module, rr_arb2: 2-way round-robin arbiter with a last-grant flop that updates on grant.
// - The remainder (FSM, latency counter, address/data registers, range check) is in this module.
// TESTING (MEMORY preloaded: [20]=instr word, [30]=5, [31]=32, [32]=3)
// 1 fetch only: if_req addr 20 -> if_gnt at G, mem_EN at G+1 with MAR=20, CS=0, if_rvalid at G+3 with the [20] word.
// 2 write then read: d_op=01, addr 33, wdata 5 -> one EN with CS=1. Then d_op=00 addr 33 -> d_rdata=5 at G+3.
// 3 indirect: d_op=10 addr 31 -> two EN pulses (MAR=31 then 32), d_rvalid at G+6 with d_rdata=3, d_err=0.
// 4 contention: if_req and d_req held from reset -> fetch granted first, data next, then alternating; no request starves.
// 5 errors: d_addr=200 -> no mem_EN, d_rvalid=d_err=1, d_rdata=0 at G+1. Pointer cell holding 150 -> one EN, then error.
// 6 reset during a write's ISSUE cycle -> mem_EN low that cycle, target cell unchanged, all outputs 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: widths, op codes, FSM states.
package mem_ctrl_pkg;

  localparam int unsigned MC_AW      = 8;
  localparam int unsigned MC_DW      = 24;
  localparam int unsigned MC_DEPTH   = 128;
  localparam int unsigned MC_MEM_LAT = 1;

  // Data-port operation encoding (also used by the CPU decode)
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_IND   = 2'b10,
    OP_RSVD  = 2'b11
  } d_op_e;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_IND_ISSUE = 3'd3,
    S_IND_WAIT  = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  // True for op codes that must be answered with an error response
  function automatic logic op_is_error(input logic [1:0] op);
    return d_op_e'(op) == OP_RSVD;
  endfunction

endpackage : mem_ctrl_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = fetch, bit 1 = data.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_c_o
);

  // 1: the data requester (bit 1) was granted most recently
  logic last_q;
  logic last_d;

  // Grant the single requester, or on a tie the one not served last
  always_comb begin
    gnt_c_o = 2'b00;
    if (en_i) begin
      if (&req_i) begin
        gnt_c_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_c_o = req_i;
      end
    end
  end

  // Remember the winner only when a grant is actually issued
  always_comb begin
    last_d = last_q;
    if (|gnt_c_o) begin
      last_d = gnt_c_o[1];
    end
  end

  // Last-grant flop; resets to "data last" so fetch wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_access_ctrl.sv
// Shares the single-port synchronous memory between the fetch and data units,
// sequences plain/indirect reads and writes, and returns read data with a pulse.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW      = MC_AW,
  parameter int unsigned DW      = MC_DW,
  parameter int unsigned DEPTH   = MC_DEPTH,
  parameter int unsigned MEM_LAT = MC_MEM_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic [1:0]    d_op,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_MAR,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_EN,
  output logic          mem_CS,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy
);

  // Counter covers the MEM_LAT+1 cycles spent in IND_WAIT
  localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;      // 0: fetch transaction, 1: data transaction
  logic          ind_q, ind_d;          // current data transaction is indirect
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] din_q, din_d;
  logic          en_q, en_d;
  logic          cs_q, cs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;
  logic          busy_q;

  logic          arb_en;
  logic [1:0]    arb_gnt;

  // Address lies inside the implemented cells
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Arbitration only happens in IDLE and never while reset is held
  assign arb_en = (state_q == S_IDLE) && !reset;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   ({d_req, if_req}),
    .en_i    (arb_en),
    .gnt_c_o (arb_gnt)
  );

  // Next-state, memory command and response generation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ind_d       = ind_q;
    mar_d       = mar_q;
    din_d       = din_q;
    en_d        = 1'b0;
    cs_d        = 1'b0;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_gnt[0]) begin
          // Fetch has no error port; its address goes to memory unchecked
          owner_d = 1'b0;
          ind_d   = 1'b0;
          mar_d   = if_addr;
          en_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (arb_gnt[1]) begin
          owner_d = 1'b1;
          ind_d   = (d_op_e'(d_op) == OP_IND);
          if (op_is_error(d_op) || !in_range(d_addr)) begin
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
            d_rdata_d  = '0;
            state_d    = S_RESP;
          end else begin
            mar_d   = d_addr;
            en_d    = 1'b1;
            cs_d    = (d_op_e'(d_op) == OP_WRITE);
            if (d_op_e'(d_op) == OP_WRITE) begin
              din_d = d_wdata;
            end
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Memory samples EN at the end of this cycle; a write is then done
        cnt_d   = '0;
        state_d = cs_q ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          if (ind_q) begin
            ptr_d   = mem_data_out[AW-1:0];
            state_d = S_IND_ISSUE;
          end else if (owner_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_data_out;
            state_d    = S_RESP;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_data_out;
            state_d     = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IND_ISSUE: begin
        // Out-of-range pointer replaces the second access with an error
        cnt_d = '0;
        if (!in_range(ptr_q)) begin
          d_rvalid_d = 1'b1;
          d_err_d    = 1'b1;
          d_rdata_d  = '0;
          state_d    = S_RESP;
        end else begin
          mar_d   = ptr_q;
          en_d    = 1'b1;
          state_d = S_IND_WAIT;
        end
      end

      S_IND_WAIT: begin
        // Spans the EN cycle plus MEM_LAT cycles of memory latency
        if (cnt_q == CNT_W'(MEM_LAT)) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_data_out;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset also kills a pending EN at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      ind_q       <= 1'b0;
      mar_q       <= '0;
      din_q       <= '0;
      en_q        <= 1'b0;
      cs_q        <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ind_q       <= ind_d;
      mar_q       <= mar_d;
      din_q       <= din_d;
      en_q        <= en_d;
      cs_q        <= cs_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign if_gnt      = arb_gnt[0];
  assign d_gnt       = arb_gnt[1];
  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign d_rvalid    = d_rvalid_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign mem_MAR     = mar_q;
  assign mem_data_in = din_q;
  assign mem_EN      = en_q;
  assign mem_CS      = cs_q;
  assign busy        = busy_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 128x24 memory.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = MC_AW;
  localparam int unsigned DW = MC_DW;
  localparam int NT = 24;
  localparam logic [DW-1:0] INSTR = 24'hA5C31E;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_gnt, d_rvalid, d_err;
  logic [1:0]    d_op;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_MAR;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_EN, mem_CS, busy;

  logic          load;
  logic [DW-1:0] mem [0:127];

  int total = 0;
  int bad   = 0;

  // Per-cycle trace of one scenario, index 0 = cycle the request is first visible
  logic          t_ig [NT];
  logic          t_dg [NT];
  logic          t_en [NT];
  logic          t_cs [NT];
  logic          t_irv [NT];
  logic          t_drv [NT];
  logic          t_derr [NT];
  logic          t_busy [NT];
  logic [AW-1:0] t_mar [NT];
  logic [DW-1:0] t_din [NT];
  logic [DW-1:0] t_ird [NT];
  logic [DW-1:0] t_drd [NT];

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(MC_DEPTH), .MEM_LAT(MC_MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_MAR(mem_MAR), .mem_data_in(mem_data_in), .mem_EN(mem_EN),
    .mem_CS(mem_CS), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Single-port synchronous memory, one-cycle read latency
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem[20] <= INSTR;
      mem[30] <= 24'd5;
      mem[31] <= 24'd32;
      mem[32] <= 24'd3;
      mem[40] <= 24'd150;
      mem[41] <= 24'h123420;
    end else if (mem_EN && !mem_MAR[7]) begin
      if (mem_CS) mem[mem_MAR] <= mem_data_in;
      else        mem_data_out <= mem[mem_MAR];
    end
  end

  // Record n cycles at the falling edge; optionally drop a request once granted
  task automatic run_cycles(input int n, input bit drop);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t_ig[k] = if_gnt;   t_dg[k] = d_gnt;    t_en[k] = mem_EN;  t_cs[k] = mem_CS;
      t_irv[k] = if_rvalid; t_drv[k] = d_rvalid; t_derr[k] = d_err; t_busy[k] = busy;
      t_mar[k] = mem_MAR; t_din[k] = mem_data_in; t_ird[k] = if_rdata; t_drd[k] = d_rdata;
      @(posedge clk);
      #1;
      if (drop && t_ig[k]) if_req = 1'b0;
      if (drop && t_dg[k]) d_req  = 1'b0;
    end
  endtask

  task automatic issue_data(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w);
    d_op = op; d_addr = a; d_wdata = w; d_req = 1'b1;
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1;
    #1;
    total++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt: got %b want 00", {if_gnt, d_gnt});
    end
    total++;
    if ({if_rvalid, d_rvalid, d_err, mem_EN, mem_CS, busy} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {if_rvalid, d_rvalid, d_err, mem_EN, mem_CS, busy});
    end
    total++;
    if ({mem_MAR, mem_data_in, if_rdata, d_rdata} !== '0) begin
      bad++; $display("FAIL reset_buses: MAR=%0d din=%h ird=%h drd=%h want all 0", mem_MAR, mem_data_in, if_rdata, d_rdata);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    if_addr = 8'd20; if_req = 1'b1;
    run_cycles(6, 1'b1);
    total++;
    if ({t_ig[0], t_dg[0], t_en[0], t_busy[0]} !== 4'b1000) begin
      bad++; $display("FAIL fetch_g: gnt/dgnt/en/busy got %b want 1000", {t_ig[0], t_dg[0], t_en[0], t_busy[0]});
    end
    total++;
    if ({t_en[1], t_cs[1], t_busy[1], t_mar[1]} !== {3'b101, 8'd20}) begin
      bad++; $display("FAIL fetch_issue: en/cs/busy=%b%b%b MAR=%0d want 101 MAR=20", t_en[1], t_cs[1], t_busy[1], t_mar[1]);
    end
    total++;
    if ({t_en[2], t_irv[2], t_irv[3], t_drv[3]} !== 4'b0010) begin
      bad++; $display("FAIL fetch_rvalid: en2/irv2/irv3/drv3 got %b want 0010", {t_en[2], t_irv[2], t_irv[3], t_drv[3]});
    end
    total++;
    if (t_ird[3] !== INSTR || t_ird[5] !== INSTR) begin
      bad++; $display("FAIL fetch_data: got %h/%h want %h", t_ird[3], t_ird[5], INSTR);
    end
    total++;
    if ({t_irv[4], t_busy[4]} !== 2'b00) begin
      bad++; $display("FAIL fetch_done: irv/busy got %b want 00", {t_irv[4], t_busy[4]});
    end
  endtask

  task automatic test_write_read();
    int n_drv;
    issue_data(2'b01, 8'd33, 24'd5);
    run_cycles(4, 1'b1);
    n_drv = 0;
    for (int k = 0; k < 4; k++) if (t_drv[k]) n_drv++;
    total++;
    if ({t_dg[0], t_en[1], t_cs[1], t_mar[1], t_din[1]} !== {3'b111, 8'd33, 24'd5}) begin
      bad++; $display("FAIL write_issue: gnt/en/cs=%b%b%b MAR=%0d din=%0d want 111 33 5", t_dg[0], t_en[1], t_cs[1], t_mar[1], t_din[1]);
    end
    total++;
    if ({t_en[2], t_busy[2], t_en[3]} !== 3'b000 || n_drv !== 0) begin
      bad++; $display("FAIL write_done: en2/busy2/en3=%b%b%b rvalids=%0d want 000 0", t_en[2], t_busy[2], t_en[3], n_drv);
    end
    total++;
    if (mem[33] !== 24'd5) begin
      bad++; $display("FAIL write_cell: got %0d want 5", mem[33]);
    end
    issue_data(2'b00, 8'd33, 24'd0);
    run_cycles(5, 1'b1);
    total++;
    if ({t_drv[2], t_drv[3], t_derr[3], t_irv[3], t_drd[3]} !== {4'b0100, 24'd5}) begin
      bad++; $display("FAIL read_back: drv2/drv3/err/irv=%b%b%b%b data=%0d want 0100 5", t_drv[2], t_drv[3], t_derr[3], t_irv[3], t_drd[3]);
    end
  endtask

  task automatic test_indirect();
    int n_en;
    issue_data(2'b10, 8'd31, 24'd0);
    run_cycles(8, 1'b1);
    n_en = 0;
    for (int k = 0; k < 8; k++) if (t_en[k]) n_en++;
    total++;
    if (n_en !== 2 || !t_en[1] || !t_en[4] || t_mar[1] !== 8'd31 || t_mar[4] !== 8'd32 || t_cs[4]) begin
      bad++; $display("FAIL ind_en: count=%0d en1=%b en4=%b MAR=%0d/%0d want 2 1 1 31/32", n_en, t_en[1], t_en[4], t_mar[1], t_mar[4]);
    end
    total++;
    if ({t_drv[5], t_drv[6], t_derr[6], t_drd[6]} !== {3'b010, 24'd3}) begin
      bad++; $display("FAIL ind_resp: drv5/drv6/err=%b%b%b data=%0d want 010 3", t_drv[5], t_drv[6], t_derr[6], t_drd[6]);
    end
    total++;
    if ({t_busy[6], t_busy[7]} !== 2'b10) begin
      bad++; $display("FAIL ind_busy: got %b want 10", {t_busy[6], t_busy[7]});
    end
    // Upper pointer bits are ignored: 0x123420 points at cell 32
    issue_data(2'b10, 8'd41, 24'd0);
    run_cycles(8, 1'b1);
    total++;
    if ({t_mar[4], t_drv[6], t_derr[6], t_drd[6]} !== {8'd32, 2'b10, 24'd3}) begin
      bad++; $display("FAIL ind_hibits: MAR=%0d drv/err=%b%b data=%0d want 32 10 3", t_mar[4], t_drv[6], t_derr[6], t_drd[6]);
    end
  endtask

  task automatic test_errors();
    logic [1:0]    ops [4];
    logic [AW-1:0] adr [4];
    int n_en;
    ops[0] = 2'b00; adr[0] = 8'd200;
    ops[1] = 2'b00; adr[1] = 8'd128;
    ops[2] = 2'b11; adr[2] = 8'd10;
    ops[3] = 2'b01; adr[3] = 8'd200;
    for (int i = 0; i < 4; i++) begin
      issue_data(ops[i], adr[i], 24'h0000FF);
      run_cycles(4, 1'b1);
      n_en = 0;
      for (int k = 0; k < 4; k++) if (t_en[k]) n_en++;
      total++;
      if ({t_dg[0], t_drv[1], t_derr[1], t_drd[1]} !== {3'b111, 24'd0} || n_en !== 0 || t_drv[2] || t_busy[2]) begin
        bad++; $display("FAIL err_%0d: gnt/drv/err=%b%b%b data=%h en=%0d drv2=%b busy2=%b want 111 0 0 0 0",
                        i, t_dg[0], t_drv[1], t_derr[1], t_drd[1], n_en, t_drv[2], t_busy[2]);
      end
    end
    // Legal boundary cell 127 is not an error
    issue_data(2'b00, 8'd127, 24'd0);
    run_cycles(5, 1'b1);
    total++;
    if ({t_en[1], t_mar[1], t_drv[3], t_derr[3]} !== {1'b1, 8'd127, 2'b10}) begin
      bad++; $display("FAIL addr127: en=%b MAR=%0d drv/err=%b%b want 1 127 10", t_en[1], t_mar[1], t_drv[3], t_derr[3]);
    end
    // Pointer cell holding 150: first read happens, then an error instead of the second
    issue_data(2'b10, 8'd40, 24'd0);
    run_cycles(7, 1'b1);
    n_en = 0;
    for (int k = 0; k < 7; k++) if (t_en[k]) n_en++;
    total++;
    if (n_en !== 1 || t_mar[1] !== 8'd40 || {t_drv[3], t_drv[4], t_derr[4], t_drd[4]} !== {3'b011, 24'd0}) begin
      bad++; $display("FAIL ptr_err: en=%0d MAR=%0d drv3/drv4/err=%b%b%b data=%h want 1 40 011 0",
                      n_en, t_mar[1], t_drv[3], t_drv[4], t_derr[4], t_drd[4]);
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    if_addr = 8'd20; if_req = 1'b1;
    issue_data(2'b00, 8'd30, 24'd0);
    @(posedge clk); #1; reset = 1'b0;
    run_cycles(NT, 1'b0);
    if_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < NT; k++) begin
      logic [1:0] want;
      want = {(k % 8 == 4), (k % 8 == 0)};
      total++;
      if ({t_dg[k], t_ig[k]} !== want) begin
        bad++; $display("FAIL contend_k%0d: dgnt/igGnt got %b want %b", k, {t_dg[k], t_ig[k]}, want);
      end
    end
    total++;
    if ({t_irv[3], t_ird[3], t_drv[7], t_drd[7], t_irv[7]} !== {1'b1, INSTR, 1'b1, 24'd5, 1'b0}) begin
      bad++; $display("FAIL contend_data: irv3=%b ird=%h drv7=%b drd=%0d irv7=%b want 1 %h 1 5 0",
                      t_irv[3], t_ird[3], t_drv[7], t_drd[7], t_irv[7], INSTR);
    end
  endtask

  task automatic test_reset_mid_write();
    issue_data(2'b01, 8'd33, 24'h000777);
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++; $display("FAIL rstw_gnt: got %b want 1", d_gnt);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_EN, mem_CS} !== 2'b11) begin
      bad++; $display("FAIL rstw_issue: en/cs got %b want 11", {mem_EN, mem_CS});
    end
    reset = 1'b1; d_req = 1'b0;
    #1;
    total++;
    if ({mem_EN, mem_CS, busy, d_rvalid, if_rvalid, d_err, d_gnt, if_gnt} !== 8'b0 ||
        {mem_MAR, mem_data_in, if_rdata, d_rdata} !== '0) begin
      bad++; $display("FAIL rstw_outs: flags=%b MAR=%0d din=%h ird=%h drd=%h want all 0",
                      {mem_EN, mem_CS, busy, d_rvalid, if_rvalid, d_err, d_gnt, if_gnt},
                      mem_MAR, mem_data_in, if_rdata, d_rdata);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    total++;
    if (mem[33] !== 24'd5) begin
      bad++; $display("FAIL rstw_cell: got %h want 000005", mem[33]);
    end
    @(posedge clk); #1;
    issue_data(2'b00, 8'd33, 24'd0);
    run_cycles(5, 1'b1);
    total++;
    if ({t_drv[3], t_derr[3], t_drd[3]} !== {2'b10, 24'd5}) begin
      bad++; $display("FAIL rstw_read: drv/err=%b%b data=%h want 10 000005", t_drv[3], t_derr[3], t_drd[3]);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1; load = 1'b0;
    test_reset();
    test_fetch();
    test_write_read();
    test_indirect();
    test_errors();
    test_contention();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_access_ctrl
